// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write bus for the program loader.
// The master side is the loader itself; the slave side is the UART/memory/CPU environment.
interface program_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8,
  parameter int NB_ADDR = 10
);
  logic               i_start;
  logic [NB_BYTE-1:0] i_byte;
  logic               i_byte_valid;
  logic               o_wr_en;
  logic [NB_ADDR-1:0] o_wr_addr;
  logic [NB_DATA-1:0] o_wr_data;
  logic               o_cpu_hold;
  logic               o_load_done;
  logic               o_load_error;
  logic [NB_ADDR:0]   o_word_count;

  modport master (
    input  i_start, i_byte, i_byte_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_load_done, o_load_error, o_word_count
  );

  modport slave (
    output i_start, i_byte, i_byte_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_cpu_hold, o_load_done, o_load_error, o_word_count
  );
endinterface

// File: rtl/program_loader.sv
// Packs an MSB-first byte stream into instruction words and writes them to program
// memory from address 0 until the halt word is stored or memory runs out.
module program_loader #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_BYTE   = 8,
  parameter int                 NB_ADDR   = 10,
  parameter int                 ROM_DEPTH = 1024,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  program_loader_if.master  io_bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSEMBLE,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t             r_state, w_state_next;
  logic [1:0]         r_byte_cnt, w_byte_cnt_next;
  logic [NB_DATA-1:0] r_word, w_word_next;
  logic [NB_ADDR-1:0] r_addr, w_addr_next;
  logic [NB_ADDR:0]   r_word_count, w_word_count_next;
  logic               r_wr_en, w_wr_en_next;
  logic [NB_ADDR-1:0] r_wr_addr, w_wr_addr_next;
  logic [NB_DATA-1:0] r_wr_data, w_wr_data_next;
  logic               r_cpu_hold, w_cpu_hold_next;
  logic               r_load_done, w_load_done_next;
  logic               r_load_error, w_load_error_next;

  logic [NB_DATA-1:0] w_shifted;
  logic               w_last_addr;

  // Word with the incoming byte appended at the bottom; older bytes move up one lane.
  genvar gi;
  generate
    for (gi = 0; gi < NB_DATA / NB_BYTE; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign w_shifted[NB_BYTE-1:0] = io_bus.i_byte;
      end else begin : g_rest
        assign w_shifted[gi*NB_BYTE +: NB_BYTE] = r_word[(gi-1)*NB_BYTE +: NB_BYTE];
      end
    end
  endgenerate

  assign w_last_addr = (r_addr == NB_ADDR'(ROM_DEPTH - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= ST_IDLE;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_cpu_hold   <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_byte_cnt   <= w_byte_cnt_next;
      r_word       <= w_word_next;
      r_addr       <= w_addr_next;
      r_word_count <= w_word_count_next;
      r_wr_en      <= w_wr_en_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_cpu_hold   <= w_cpu_hold_next;
      r_load_done  <= w_load_done_next;
      r_load_error <= w_load_error_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_byte_cnt_next   = r_byte_cnt;
    w_word_next       = r_word;
    w_addr_next       = r_addr;
    w_word_count_next = r_word_count;
    w_wr_addr_next    = r_wr_addr;
    w_wr_data_next    = r_wr_data;
    w_cpu_hold_next   = r_cpu_hold;
    w_load_done_next  = r_load_done;
    w_load_error_next = r_load_error;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (io_bus.i_start) begin
          w_state_next      = ST_ASSEMBLE;
          w_addr_next       = '0;
          w_byte_cnt_next   = '0;
          w_word_count_next = '0;
          w_cpu_hold_next   = 1'b1;
          w_load_done_next  = 1'b0;
          w_load_error_next = 1'b0;
        end
      end

      ST_ASSEMBLE: begin
        if (io_bus.i_byte_valid) begin
          w_word_next     = w_shifted;
          w_byte_cnt_next = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            // Write outputs are loaded here so they are valid during the WRITE cycle.
            w_state_next      = ST_WRITE;
            w_wr_addr_next    = r_addr;
            w_wr_data_next    = w_shifted;
            w_word_count_next = r_word_count + 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (r_word == HALT_WORD) begin
          w_state_next     = ST_DONE;
          w_load_done_next = 1'b1;
          w_cpu_hold_next  = 1'b0;
        end else if (w_last_addr) begin
          w_state_next      = ST_ERROR;
          w_load_error_next = 1'b1;
        end else begin
          w_state_next = ST_ASSEMBLE;
          w_addr_next  = r_addr + 1'b1;
          // A byte arriving back-to-back with the write opens the next word.
          if (io_bus.i_byte_valid) begin
            w_word_next     = w_shifted;
            w_byte_cnt_next = 2'd1;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    w_wr_en_next = (w_state_next == ST_WRITE);
  end

  assign io_bus.o_wr_en      = r_wr_en;
  assign io_bus.o_wr_addr    = r_wr_addr;
  assign io_bus.o_wr_data    = r_wr_data;
  assign io_bus.o_cpu_hold   = r_cpu_hold;
  assign io_bus.o_load_done  = r_load_done;
  assign io_bus.o_load_error = r_load_error;
  assign io_bus.o_word_count = r_word_count;

endmodule
